pi_seq_ctrl: RTL and testbench
==============================

PI_SEQ_CTRL -- requirements
Module: pi_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2; number of 16-bit output buffer entries.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port req  input  1  host start request, sampled in IDLE only.
REQ-005 SHALL have port num_words  input  8  number of 16-bit pi words to deliver, latched on accepted req.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port core_start  output  1  one-cycle start pulse to the calc_pi core.
REQ-008 SHALL have port core_decimal_out  input  16  result word from the core.
REQ-009 SHALL have port core_valid  input  1  core_decimal_out qualifier; the core has no backpressure.
REQ-010 SHALL have port core_done  input  1  core finished; no further words will follow.
REQ-011 SHALL have ports m_data (output 16), m_valid (output 1), m_ready (input 1), m_last (output 1): downstream ready/valid stream.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of a run.
REQ-013 SHALL have ports overflow and short_run, each output 1: sticky status, cleared on the next accepted req.

Function
REQ-014 SHALL implement states IDLE, START, RUN, DRAIN, DONE.
REQ-015 IDLE: req=1 with num_words!=0 -> START; req=1 with num_words=0 -> DONE, core_start never pulsed; req while busy SHALL be ignored.
REQ-016 START: core_start=1 for exactly this cycle; word counter cleared; -> RUN.
REQ-017 RUN: each core_valid cycle with counter < num_words SHALL push core_decimal_out into the FIFO and increment the counter; words with counter >= num_words SHALL be discarded without setting overflow.
REQ-018 RUN -> DRAIN when counter reaches num_words or on core_done; core_done with counter < num_words SHALL set short_run.
REQ-019 DRAIN -> DONE when FIFO empty; DONE asserts done for one cycle -> IDLE.
REQ-020 Push when FIFO full and no pop in the same cycle SHALL drop the word, set overflow, and still increment the counter; push and pop on a full FIFO in the same cycle SHALL both succeed.
REQ-021 Latency: word pushed at edge N SHALL be visible on m_data with m_valid=1 from edge N+1; FIFO order preserved.
REQ-022 m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0; pop only when m_valid and m_ready both high.
REQ-023 m_last SHALL be 1 only with the word of index num_words-1 (0-based); early-terminated runs produce no m_last.
REQ-024 Pointers and counter SHALL wrap modulo their width without corruption; num_words=255 SHALL deliver 255 words.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, empty FIFO, counter 0, and busy, core_start, m_valid, m_last, done, overflow, short_run all 0; m_data 0.
REQ-026 Reset mid-run SHALL discard buffered words; no done pulse SHALL follow reset release.

Configuration
REQ-027 With macro PI_SEQ_CHECK_EN defined, the block SHALL add output mismatch (1 bit, sticky, cleared on accepted req) and compare each pushed word of index 0-7 against 0x243F,0x6A88,0x85A3,0x08D3,0x1319,0x8A2E,0x0370,0x7344, setting mismatch on any difference; indices >= 8 unchecked.
REQ-028 Without PI_SEQ_CHECK_EN, no mismatch port and no compare logic SHALL exist; all other behaviour identical.

Verification
REQ-029 Reset: after rst_n pulse low, all outputs 0 and state IDLE.
REQ-030 Normal: num_words=4, core_valid delivers 0x243F,0x6A88,0x85A3,0x08D3, m_ready=1 -> one core_start pulse, same four words in order, m_last on 0x08D3, done pulse, overflow=0, mismatch=0.
REQ-031 Backpressure: num_words=6, m_ready=0, six back-to-back core_valid, FIFO_DEPTH=4 -> words 5,6 dropped, overflow=1, first four delivered once m_ready=1.
REQ-032 Early done: num_words=8, core_done after 3 words -> 3 words out, no m_last, short_run=1, done pulse.
REQ-033 Zero/ignored: num_words=0 -> done pulse, no core_start; req during RUN -> no second core_start.
REQ-034 Check and mid-run reset: second word 0x6A89 with PI_SEQ_CHECK_EN -> mismatch=1; rst_n low during RUN -> m_valid=0, busy=0 immediately.

Source files
------------

// File: rtl/pi_seq_ctrl.sv
// Sequencer between a host, the calc_pi core and a ready/valid word stream.
// Optional reference compare of the first eight pi words: define PI_SEQ_CHECK_EN.
module pi_seq_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  num_words,
  output logic        busy,
  output logic        core_start,
  input  logic [15:0] core_decimal_out,
  input  logic        core_valid,
  input  logic        core_done,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        done,
  output logic        overflow,
  output logic        short_run
`ifdef PI_SEQ_CHECK_EN
  ,
  output logic        mismatch
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;

  state_t             state_reg;
  logic [7:0]         num_words_reg;
  logic [7:0]         word_cnt_reg;
  logic               busy_reg;
  logic               core_start_reg;
  logic               done_reg;
  logic               overflow_reg;
  logic               short_run_reg;

  // Each entry carries its last-word flag in bit 16.
  logic [16:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [15:0]        m_data_reg;
  logic               m_valid_reg;
  logic               m_last_reg;

  logic               push_req;
  logic               pop;
  logic               fifo_full;
  logic               fifo_wr;
  logic               fifo_load;
  logic               push_last;
  logic [7:0]         word_cnt_inc;
  logic [PTR_W-1:0]   rd_addr;

  assign push_req     = (state_reg == RUN) && core_valid && (word_cnt_reg < num_words_reg);
  assign pop          = m_valid_reg && m_ready;
  assign fifo_full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_wr      = push_req && (!fifo_full || pop);
  assign push_last    = (word_cnt_reg == (num_words_reg - 8'd1));
  assign word_cnt_inc = word_cnt_reg + 8'd1;

  // The output register always mirrors the FIFO head; on a pop it fetches the
  // next entry only if that entry was written on an earlier edge.
  assign rd_addr   = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
  assign fifo_load = pop ? (count_reg > CNT_W'(1)) : (!m_valid_reg && (count_reg != '0));

`ifdef PI_SEQ_CHECK_EN
  localparam logic [15:0] PI_REF [8] = '{
    16'h243F, 16'h6A88, 16'h85A3, 16'h08D3,
    16'h1319, 16'h8A2E, 16'h0370, 16'h7344
  };

  logic [7:0] ref_miss;
  logic       word_miss;
  logic       mismatch_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ref
      assign ref_miss[gi] = (word_cnt_reg == 8'(gi)) && (core_decimal_out != PI_REF[gi]);
    end
  endgenerate

  assign word_miss = push_req && (|ref_miss);
  assign mismatch  = mismatch_reg;
`endif

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr_reg] <= {push_last, core_decimal_out};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      m_data_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      unique case ({fifo_wr, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (fifo_load) begin
        m_data_reg  <= mem[rd_addr][15:0];
        m_last_reg  <= mem[rd_addr][16];
        m_valid_reg <= 1'b1;
      end else if (pop) begin
        m_valid_reg <= 1'b0;
        m_last_reg  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      num_words_reg  <= '0;
      word_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
      core_start_reg <= 1'b0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      short_run_reg  <= 1'b0;
`ifdef PI_SEQ_CHECK_EN
      mismatch_reg   <= 1'b0;
`endif
    end else begin
      core_start_reg <= 1'b0;
      done_reg       <= 1'b0;
      // Dropped words still advance the counter so the run length stays exact.
      if (push_req) begin
        word_cnt_reg <= word_cnt_inc;
        if (fifo_full && !pop) begin
          overflow_reg <= 1'b1;
        end
      end
`ifdef PI_SEQ_CHECK_EN
      if (word_miss) begin
        mismatch_reg <= 1'b1;
      end
`endif
      unique case (state_reg)
        IDLE: begin
          if (req) begin
            num_words_reg <= num_words;
            overflow_reg  <= 1'b0;
            short_run_reg <= 1'b0;
`ifdef PI_SEQ_CHECK_EN
            mismatch_reg  <= 1'b0;
`endif
            busy_reg      <= 1'b1;
            if (num_words != 8'd0) begin
              state_reg      <= START;
              core_start_reg <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        START: begin
          word_cnt_reg <= '0;
          state_reg    <= RUN;
        end
        RUN: begin
          if (push_req && (word_cnt_inc == num_words_reg)) begin
            state_reg <= DRAIN;
          end else if (core_done) begin
            short_run_reg <= 1'b1;
            state_reg     <= DRAIN;
          end
        end
        DRAIN: begin
          if (count_reg == '0) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign core_start = core_start_reg;
  assign done       = done_reg;
  assign overflow   = overflow_reg;
  assign short_run  = short_run_reg;
  assign m_data     = m_data_reg;
  assign m_valid    = m_valid_reg;
  assign m_last     = m_last_reg;

endmodule

// File: tb/tb_pi_seq_ctrl.sv
// Directed bench for pi_seq_ctrl with a queue-based reference model checked every cycle.
// Build with PI_SEQ_CHECK_EN defined to also exercise the mismatch output.
module tb_pi_seq_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  num_words = 8'd0;
  logic        busy;
  logic        core_start;
  logic [15:0] core_decimal_out = 16'd0;
  logic        core_valid = 1'b0;
  logic        core_done = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        done;
  logic        overflow;
  logic        short_run;
`ifdef PI_SEQ_CHECK_EN
  logic        mismatch;
`endif

  always #5 clk = ~clk;

  pi_seq_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .num_words        (num_words),
    .busy             (busy),
    .core_start       (core_start),
    .core_decimal_out (core_decimal_out),
    .core_valid       (core_valid),
    .core_done        (core_done),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last),
    .done             (done),
    .overflow         (overflow),
    .short_run        (short_run)
`ifdef PI_SEQ_CHECK_EN
    ,
    .mismatch         (mismatch)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0] pi_tab [8] = '{16'h243F, 16'h6A88, 16'h85A3, 16'h08D3,
                              16'h1319, 16'h8A2E, 16'h0370, 16'h7344};

  function automatic logic [15:0] word_at(input int i);
    if (i < 8) return pi_tab[i];
    return 16'(i * 37 + 5);
  endfunction

  // Reference model: the buffer is a queue of words stamped with the edge that
  // wrote them; the head is visible once an edge later than its stamp has passed.
  typedef struct {
    logic [15:0] data;
    bit          last;
    int          stamp;
  } ent_t;

  localparam int S_IDLE = 0, S_START = 1, S_RUN = 2, S_DRAIN = 3, S_DONE = 4;

  ent_t mq[$];
  ent_t ent;
  int   ms = S_IDLE;
  int   m_nw = 0;
  int   m_cnt = 0;
  int   cyc = 0;
  int   pre_size = 0;
  bit   m_ovf = 0, m_sr = 0, m_mis = 0, m_valid_e = 0;
  bit   pop_e, push_e, full_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms = S_IDLE;
      mq.delete();
      m_nw = 0; m_cnt = 0;
      m_ovf = 0; m_sr = 0; m_mis = 0; m_valid_e = 0;
    end else begin
      cyc++;
      pop_e    = m_valid_e && m_ready;
      pre_size = mq.size();
      full_e   = (pre_size == DEPTH);
      push_e   = (ms == S_RUN) && core_valid && (m_cnt < m_nw);
      if (pop_e) void'(mq.pop_front());
      if (push_e) begin
        if (full_e && !pop_e) begin
          m_ovf = 1;
        end else begin
          ent.data  = core_decimal_out;
          ent.last  = (m_cnt == m_nw - 1);
          ent.stamp = cyc;
          mq.push_back(ent);
        end
        if (m_cnt < 8 && core_decimal_out != pi_tab[m_cnt]) m_mis = 1;
        m_cnt++;
      end
      case (ms)
        S_IDLE: if (req) begin
          m_nw = int'(num_words);
          m_ovf = 0; m_sr = 0; m_mis = 0;
          ms = (num_words != 0) ? S_START : S_DONE;
        end
        S_START: begin m_cnt = 0; ms = S_RUN; end
        S_RUN: begin
          if (push_e && m_cnt == m_nw) ms = S_DRAIN;
          else if (core_done) begin m_sr = 1; ms = S_DRAIN; end
        end
        S_DRAIN: if (pre_size == 0) ms = S_DONE;
        default: ms = S_IDLE;
      endcase
      m_valid_e = (mq.size() > 0) && (mq[0].stamp < cyc);
    end
  end

  int          n_starts = 0;
  int          n_dones  = 0;
  logic [15:0] got_data[$];
  bit          got_last[$];

  // Compare process plus delivery log, both on the falling edge.
  always @(negedge clk) begin
    check("busy",       32'(busy),       32'(ms != S_IDLE));
    check("core_start", 32'(core_start), 32'(ms == S_START));
    check("done",       32'(done),       32'(ms == S_DONE));
    check("m_valid",    32'(m_valid),    32'(m_valid_e));
    check("m_last",     32'(m_last),     32'(m_valid_e && mq[0].last));
    if (m_valid_e) check("m_data", 32'(m_data), 32'(mq[0].data));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("short_run",  32'(short_run),  32'(m_sr));
`ifdef PI_SEQ_CHECK_EN
    check("mismatch",   32'(mismatch),   32'(m_mis));
`endif
    if (core_start) n_starts++;
    if (done) n_dones++;
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
    end
  end

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    n_starts = 0;
    n_dones  = 0;
  endtask

  task automatic start_run(input int nw);
    @(posedge clk); #1;
    req = 1'b1;
    num_words = 8'(nw);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic send_words(input int n, input int first, input int bad, input int ready_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == ready_at) m_ready = 1'b1;
      core_valid = 1'b1;
      core_decimal_out = word_at(first + i) ^ ((i == bad) ? 16'h0001 : 16'h0000);
    end
    @(posedge clk); #1;
    core_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got no done pulse, expected one within 2000 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string name, input int n, input int first, input int last_idx,
                           input logic [15:0] flip1);
    check($sformatf("%s_count", name), 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), 32'(got_data[i]),
            32'(word_at(first + i) ^ ((i == 1) ? flip1 : 16'h0000)));
      check($sformatf("%s_last%0d", name, i), 32'(got_last[i]), 32'(i == last_idx));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_short_run", 32'(short_run), 32'd0);

    // Normal four-word run
    clear_log(); m_ready = 1'b1;
    start_run(4); send_words(4, 0, -1, 999); wait_done("normal");
    check_log("normal", 4, 0, 3, 16'h0000);
    check("normal_starts", 32'(n_starts), 32'd1);
    check("normal_dones", 32'(n_dones), 32'd1);
    check("normal_overflow", 32'(overflow), 32'd0);
    check("normal_m_data_last", 32'(got_data[3]), 32'h08D3);

    // Backpressure overflow: words 5 and 6 dropped
    clear_log(); m_ready = 1'b0;
    start_run(6); send_words(6, 0, -1, 999);
    repeat (3) @(posedge clk); #1;
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_model_ovf", 32'(m_ovf), 32'd1);
    check("bp_hold_valid", 32'(m_valid), 32'd1);
    check("bp_hold_data", 32'(m_data), 32'h243F);
    m_ready = 1'b1;
    wait_done("bp");
    check_log("bp", 4, 0, -1, 16'h0000);
    check("bp_dones", 32'(n_dones), 32'd1);

    // Early core_done after three of eight words
    clear_log(); m_ready = 1'b1;
    start_run(8); send_words(3, 0, -1, 999);
    core_done = 1'b1; @(posedge clk); #1; core_done = 1'b0;
    wait_done("early");
    check_log("early", 3, 0, -1, 16'h0000);
    check("early_short_run", 32'(short_run), 32'd1);
    check("early_model_sr", 32'(m_sr), 32'd1);
    check("early_dones", 32'(n_dones), 32'd1);

    // Zero-length request
    clear_log();
    start_run(0); wait_done("zero");
    check("zero_starts", 32'(n_starts), 32'd0);
    check("zero_dones", 32'(n_dones), 32'd1);
    check("zero_count", 32'(got_data.size()), 32'd0);

    // Request during RUN is ignored
    clear_log();
    start_run(3); send_words(1, 0, -1, 999);
    req = 1'b1; num_words = 8'd5; @(posedge clk); #1; req = 1'b0;
    send_words(2, 1, -1, 999); wait_done("ignore");
    check_log("ignore", 3, 0, 2, 16'h0000);
    check("ignore_starts", 32'(n_starts), 32'd1);

    // Corrupted second word and extra word beyond num_words
    clear_log();
    start_run(2); send_words(3, 0, 1, 999); wait_done("bad");
    check_log("bad", 2, 0, 1, 16'h0001);
    check("bad_overflow", 32'(overflow), 32'd0);
`ifdef PI_SEQ_CHECK_EN
    check("bad_mismatch", 32'(mismatch), 32'd1);
`endif

    // Full FIFO with simultaneous push and pop
    clear_log(); m_ready = 1'b0;
    start_run(8); send_words(8, 0, -1, 4); wait_done("fullpp");
    check_log("fullpp", 8, 0, 7, 16'h0000);
    check("fullpp_overflow", 32'(overflow), 32'd0);

    // 255-word run for pointer wrap
    clear_log(); m_ready = 1'b1;
    start_run(255); send_words(255, 0, -1, 999); wait_done("long");
    check("long_count", 32'(got_data.size()), 32'd255);
    if (got_data.size() == 255) begin
      check("long_last_flag", 32'(got_last[254]), 32'd1);
      check("long_last_data", 32'(got_data[254]), 32'(word_at(254)));
      check("long_prev_flag", 32'(got_last[253]), 32'd0);
    end
    check("long_overflow", 32'(overflow), 32'd0);

    // Reset while running with buffered words
    clear_log(); m_ready = 1'b0;
    start_run(8); send_words(2, 0, -1, 999);
    @(posedge clk); #1;
    check("mrst_pre_valid", 32'(m_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_m_data", 32'(m_data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("mrst_no_done", 32'(n_dones), 32'd0);
    check("mrst_no_data", 32'(got_data.size()), 32'd0);
    check("mrst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
